// File: rtl/dnn_param_pkg.sv
// Shared constants, slot offsets and FSM state type for the DNN parameter loader.
package dnn_param_pkg;

    localparam int N_W1          = 12;
    localparam int N_W2          = 6;
    localparam int N_B1          = 3;
    localparam int N_B2          = 2;
    localparam int PAYLOAD_BYTES = 28;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Byte offsets of each parameter group inside the payload / shadow file
    localparam int W2_BASE = 12;
    localparam int B1_BASE = 18;
    localparam int B2_BASE = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/dnn_param_loader.sv
// Run-time loader for the 4-3-2 DNN weights and biases.
// Unpacks a SYNC-prefixed byte stream into a shadow register file and copies
// the whole shadow to the live outputs in a single edge once a frame is complete.
// Optional build macro: DNN_PARAM_CHECKSUM_EN adds a trailing 8-bit sum byte,
// the CHECK state and a functional load_err pulse.
module dnn_param_loader #(
    parameter int         N_W1      = dnn_param_pkg::N_W1,
    parameter int         N_W2      = dnn_param_pkg::N_W2,
    parameter int         N_B1      = dnn_param_pkg::N_B1,
    parameter int         N_B2      = dnn_param_pkg::N_B2,
    parameter logic [7:0] SYNC_BYTE = dnn_param_pkg::SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        abort,
    output logic [7:0]  weights_layer1 [0:N_W1-1],
    output logic [7:0]  weights_layer2 [0:N_W2-1],
    output logic [15:0] bias_layer1    [0:N_B1-1],
    output logic [15:0] bias_layer2    [0:N_B2-1],
    output logic        params_valid,
    output logic        load_done,
    output logic        load_err
);

    import dnn_param_pkg::*;

    // Payload layout derived from the counts so the slot map follows the parameters
    localparam int W2_B  = N_W1;
    localparam int B1_B  = W2_B + N_W2;
    localparam int B2_B  = B1_B + 2 * N_B1;
    localparam int PAY   = B2_B + 2 * N_B2;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shadow_q [0:PAY-1];
    logic             shadow_we;
    logic             accept;
    logic             commit;
    logic             params_valid_q;
    logic             load_done_q;
    logic             err_d;

`ifdef DNN_PARAM_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic             load_err_q;
`endif

    // Ready depends only on registered state: the commit cycle is the one stall
    assign in_ready = (state_q != COMMIT);
    assign accept   = in_valid && in_ready;
    assign commit   = (state_q == COMMIT);

    // Next-state, byte counter and running-sum decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_we = 1'b0;
        err_d     = 1'b0;
`ifdef DNN_PARAM_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                // Non-sync bytes are consumed and dropped while hunting for a frame
                if (!abort && accept && (in_data == SYNC_BYTE)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
`ifdef DNN_PARAM_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    shadow_we = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
`ifdef DNN_PARAM_CHECKSUM_EN
                    sum_d     = sum_q + in_data;
                    if (cnt_q == LAST_CNT) state_d = CHECK;
`else
                    if (cnt_q == LAST_CNT) state_d = COMMIT;
`endif
                end
            end
            CHECK: begin
`ifdef DNN_PARAM_CHECKSUM_EN
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (in_data == sum_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            COMMIT: begin
                // Commit always completes; abort is ignored here
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, byte counter and running checksum registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef DNN_PARAM_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef DNN_PARAM_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Shadow register file, written one byte per accepted payload byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAY; i++) shadow_q[i] <= '0;
        end else if (shadow_we) begin
            shadow_q[cnt_q] <= in_data;
        end
    end

    // Live parameter registers, copied from the shadow in one edge on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_W1; i++) weights_layer1[i] <= '0;
            for (int i = 0; i < N_W2; i++) weights_layer2[i] <= '0;
            for (int i = 0; i < N_B1; i++) bias_layer1[i]    <= '0;
            for (int i = 0; i < N_B2; i++) bias_layer2[i]    <= '0;
        end else if (commit) begin
            for (int i = 0; i < N_W1; i++) weights_layer1[i] <= shadow_q[i];
            for (int i = 0; i < N_W2; i++) weights_layer2[i] <= shadow_q[W2_B + i];
            // Biases are stored low byte first
            for (int i = 0; i < N_B1; i++)
                bias_layer1[i] <= {shadow_q[B1_B + 2*i + 1], shadow_q[B1_B + 2*i]};
            for (int i = 0; i < N_B2; i++)
                bias_layer2[i] <= {shadow_q[B2_B + 2*i + 1], shadow_q[B2_B + 2*i]};
        end
    end

    // Status flags: sticky valid and a one-cycle done pulse per commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            params_valid_q <= 1'b0;
            load_done_q    <= 1'b0;
        end else begin
            params_valid_q <= params_valid_q | commit;
            load_done_q    <= commit;
        end
    end

    assign params_valid = params_valid_q;
    assign load_done    = load_done_q;

`ifdef DNN_PARAM_CHECKSUM_EN
    // Registered one-cycle error pulse after a bad checksum byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) load_err_q <= 1'b0;
        else     load_err_q <= err_d;
    end

    assign load_err = load_err_q;
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_dnn_param_loader.sv
// Directed bench for dnn_param_loader; follows DNN_PARAM_CHECKSUM_EN like the RTL.
module tb_dnn_param_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic [7:0]  w1 [0:11];
    logic [7:0]  w2 [0:5];
    logic [15:0] b1 [0:2];
    logic [15:0] b2 [0:1];
    logic        params_valid;
    logic        load_done;
    logic        load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_low = 0;
    int done_cnt = 0;

    logic [7:0] std_p [28];
    logic [7:0] alt_p [28];
    logic [7:0] frm   [28];

    dnn_param_loader dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .abort          (abort),
        .weights_layer1 (w1),
        .weights_layer2 (w2),
        .bias_layer1    (b1),
        .bias_layer2    (b2),
        .params_valid   (params_valid),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    always #5 clk = ~clk;

    // Counts stall cycles and done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (!in_ready) rdy_low++;
        if (load_done) done_cnt++;
    end

    // Live output byte that corresponds to payload slot k
    function automatic logic [7:0] live_byte(input int k);
        int j;
        if (k < 12) return w1[k];
        if (k < 18) return w2[k-12];
        if (k < 24) begin
            j = (k - 18) / 2;
            return ((k - 18) % 2 == 0) ? b1[j][7:0] : b1[j][15:8];
        end
        j = (k - 24) / 2;
        return ((k - 24) % 2 == 0) ? b2[j][7:0] : b2[j][15:8];
    endfunction

    // Offer one byte and hold it until accepted; returns #1 after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 50) begin
                $display("FAIL send_byte timeout: in_ready stuck at %b, required 1", in_ready);
                $fatal(1, "in_ready never returned");
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int gapmax);
        int g;
        g = $urandom_range(gapmax, 0);
        repeat (g) begin @(posedge clk); #1; end
    endtask

    // SYNC + frm[] payload (+ checksum adjusted by cdelta when enabled)
    task automatic send_frame(input int gapmax, input int cdelta);
        logic [7:0] s;
        s = 8'h00;
        idle_gap(gapmax);
        send_byte(8'hA5);
        for (int k = 0; k < 28; k++) begin
            idle_gap(gapmax);
            send_byte(frm[k]);
            s = s + frm[k];
        end
`ifdef DNN_PARAM_CHECKSUM_EN
        idle_gap(gapmax);
        send_byte(s + 8'(cdelta));
`else
        if (cdelta != 0) s = s + 8'(cdelta);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (params_valid !== 1'b0) begin n_bad++; $display("FAIL reset_params_valid got %b want 0", params_valid); end
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done got %b want 0", load_done); end
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_load_err got %b want 0", load_err); end
        for (int k = 0; k < 28; k++) begin
            n_cmp++;
            if (live_byte(k) !== 8'h00) begin n_bad++; $display("FAIL reset_slot%0d got %h want 00", k, live_byte(k)); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_std();
        frm = std_p;
        done_cnt = 0;
        send_frame(0, 0);
        // Last byte just accepted: commit cycle in progress
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL std_commit_ready got %b want 0", in_ready); end
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL std_done_early got %b want 0", load_done); end
        n_cmp++; if (w1[2] !== 8'h00) begin n_bad++; $display("FAIL std_w1_2_early got %h want 00", w1[2]); end
        @(posedge clk); #1;
        n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL std_done got %b want 1", load_done); end
        n_cmp++; if (params_valid !== 1'b1) begin n_bad++; $display("FAIL std_params_valid got %b want 1", params_valid); end
        n_cmp++; if (w1[2] !== 8'hFE) begin n_bad++; $display("FAIL std_w1_2 got %h want FE", w1[2]); end
        n_cmp++; if (b1[1] !== 16'hFFFE) begin n_bad++; $display("FAIL std_b1_1 got %h want FFFE", b1[1]); end
        n_cmp++; if (b2[1] !== 16'hFFD1) begin n_bad++; $display("FAIL std_b2_1 got %h want FFD1", b2[1]); end
        n_cmp++; if (b1[0] !== 16'h1234) begin n_bad++; $display("FAIL std_b1_0 got %h want 1234", b1[0]); end
        n_cmp++; if (b2[0] !== 16'h7FFF) begin n_bad++; $display("FAIL std_b2_0 got %h want 7FFF", b2[0]); end
        n_cmp++; if (w2[5] !== 8'h85) begin n_bad++; $display("FAIL std_w2_5 got %h want 85", w2[5]); end
        for (int k = 0; k < 28; k++) begin
            n_cmp++;
            if (live_byte(k) !== frm[k]) begin n_bad++; $display("FAIL std_slot%0d got %h want %h", k, live_byte(k), frm[k]); end
        end
        @(posedge clk); #1;
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL std_done_width got %b want 0", load_done); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL std_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_garbage();
        // Partial frame cut off by reset must leave nothing behind
        send_byte(8'hA5);
        for (int k = 0; k < 5; k++) send_byte(8'h77);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (params_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b want 0", params_valid); end
        n_cmp++; if (w1[2] !== 8'h00) begin n_bad++; $display("FAIL rst_mid_w1_2 got %h want 00", w1[2]); end
        rst = 1'b0;
        @(posedge clk); #1;
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'h13);
        frm = std_p;
        send_frame(0, 0);
        @(posedge clk); #1;
        n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL garbage_done got %b want 1", load_done); end
        n_cmp++; if (b2[1] !== 16'hFFD1) begin n_bad++; $display("FAIL garbage_b2_1 got %h want FFD1", b2[1]); end
        for (int k = 0; k < 28; k++) begin
            n_cmp++;
            if (live_byte(k) !== frm[k]) begin n_bad++; $display("FAIL garbage_slot%0d got %h want %h", k, live_byte(k), frm[k]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        send_byte(8'hA5);
        for (int k = 0; k < 10; k++) send_byte(8'h11);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++; if (params_valid !== 1'b1) begin n_bad++; $display("FAIL abort_valid got %b want 1", params_valid); end
        n_cmp++; if (w1[0] !== 8'h01) begin n_bad++; $display("FAIL abort_w1_0 got %h want 01", w1[0]); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b want 1", in_ready); end
        frm = alt_p;
        send_frame(0, 0);
        @(posedge clk); #1;
        n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL abort_done got %b want 1", load_done); end
        for (int k = 0; k < 28; k++) begin
            n_cmp++;
            if (live_byte(k) !== frm[k]) begin n_bad++; $display("FAIL abort_slot%0d got %h want %h", k, live_byte(k), frm[k]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        frm = std_p;
        rdy_low = 0;
        send_frame(5, 0);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (rdy_low !== 1) begin n_bad++; $display("FAIL gaps_ready_low got %0d want 1", rdy_low); end
        n_cmp++; if (b1[1] !== 16'hFFFE) begin n_bad++; $display("FAIL gaps_b1_1 got %h want FFFE", b1[1]); end
        for (int k = 0; k < 28; k++) begin
            n_cmp++;
            if (live_byte(k) !== frm[k]) begin n_bad++; $display("FAIL gaps_slot%0d got %h want %h", k, live_byte(k), frm[k]); end
        end
    endtask

    task automatic test_back_to_back();
        rdy_low = 0;
        done_cnt = 0;
        frm = alt_p;
        send_frame(0, 0);
        frm = std_p;
        send_frame(0, 0);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (done_cnt !== 2) begin n_bad++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        n_cmp++; if (rdy_low !== 2) begin n_bad++; $display("FAIL b2b_ready_low got %0d want 2", rdy_low); end
        for (int k = 0; k < 28; k++) begin
            n_cmp++;
            if (live_byte(k) !== frm[k]) begin n_bad++; $display("FAIL b2b_slot%0d got %h want %h", k, live_byte(k), frm[k]); end
        end
    endtask

`ifdef DNN_PARAM_CHECKSUM_EN
    task automatic test_checksum();
        done_cnt = 0;
        frm = alt_p;
        send_frame(0, 1);
        n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL csum_err_pulse got %b want 1", load_err); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL csum_err_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL csum_err_width got %b want 0", load_err); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL csum_err_done got %0d want 0", done_cnt); end
        n_cmp++; if (params_valid !== 1'b1) begin n_bad++; $display("FAIL csum_err_valid got %b want 1", params_valid); end
        n_cmp++; if (w1[2] !== 8'hFE) begin n_bad++; $display("FAIL csum_err_w1_2 got %h want FE", w1[2]); end
        send_frame(0, 0);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL csum_ok_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL csum_ok_done got %b want 1", load_done); end
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL csum_ok_err got %b want 0", load_err); end
        for (int k = 0; k < 28; k++) begin
            n_cmp++;
            if (live_byte(k) !== frm[k]) begin n_bad++; $display("FAIL csum_ok_slot%0d got %h want %h", k, live_byte(k), frm[k]); end
        end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_no_checksum();
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL nocsum_err got %b want 0", load_err); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 12; i++) std_p[i] = 8'(i + 1);
        std_p[2] = 8'hFE;
        for (int i = 0; i < 6; i++) std_p[12 + i] = 8'(8'h80 + i);
        std_p[18] = 8'h34; std_p[19] = 8'h12;
        std_p[20] = 8'hFE; std_p[21] = 8'hFF;
        std_p[22] = 8'h00; std_p[23] = 8'h01;
        std_p[24] = 8'hFF; std_p[25] = 8'h7F;
        std_p[26] = 8'hD1; std_p[27] = 8'hFF;
        for (int i = 0; i < 28; i++) alt_p[i] = 8'(i * 7 + 3);

        test_reset();
        test_std();
        test_garbage();
        test_abort();
        test_gaps();
        test_back_to_back();
`ifdef DNN_PARAM_CHECKSUM_EN
        test_checksum();
`else
        test_no_checksum();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dnn_param_loader.md
# dnn_param_loader

Receives a byte stream from the host side of the accelerator and unpacks it into the layer-1/layer-2 weight and bias registers that the 4-3-2 DNN datapath consumes. The block is the run-time counterpart of the compile-time parameter initialiser. Payload bytes are collected into shadow registers. The live outputs are updated atomically only after a complete, optionally checksum-verified frame.

## Interface
Parameters:
- `N_W1`, 12, layer-1 weight count (4 inputs × 3 neurons)
- `N_W2`, 6, layer-2 weight count (3 × 2)
- `N_B1`, 3, layer-1 bias count
- `N_B2`, 2, layer-2 bias count
- `SYNC_BYTE`, 8'hA5, frame start marker

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — asynchronous, active-high reset
- `in_data` in 8 — stream byte
- `in_valid` in 1 — `in_data` valid
- `in_ready` out 1 — block accepts a byte this cycle
- `abort` in 1 — synchronous frame abort
- `weights_layer1` out 8 × [0:N_W1-1] — live layer-1 weights (two's complement)
- `weights_layer2` out 8 × [0:N_W2-1] — live layer-2 weights
- `bias_layer1` out 16 × [0:N_B1-1] — live layer-1 biases
- `bias_layer2` out 16 × [0:N_B2-1] — live layer-2 biases
- `params_valid` out 1 — sticky; set on the first successful commit
- `load_done` out 1 — one-cycle pulse per successful commit
- `load_err` out 1 — one-cycle pulse on checksum mismatch

## Operation
- A byte transfers on a rising `clk` edge when `in_valid && in_ready`.
- Frame layout: `SYNC_BYTE`, then 28 payload bytes in this order:
  - `weights_layer1[0..11]`
  - `weights_layer2[0..5]`
  - `bias_layer1[0..2]`
  - `bias_layer2[0..1]`
  - Each bias is 2 bytes, low byte first.
  - With `DNN_PARAM_CHECKSUM_EN`, one trailing checksum byte follows.
- FSM states:
  - IDLE: accepted bytes other than `SYNC_BYTE` are consumed and dropped. `SYNC_BYTE` → LOAD, and the byte counter is cleared.
  - LOAD: each accepted byte is written to shadow slot `cnt`, and `cnt` increments (5-bit). Accepting byte `cnt==27` → CHECK if checksum is enabled, else COMMIT.
  - CHECK: accepts one byte. If it equals the running 8-bit sum of the payload (mod 256) → COMMIT. Otherwise `load_err` pulses and the FSM returns to IDLE; live registers are untouched.
  - COMMIT: copies the whole shadow to the live outputs in one edge, pulses `load_done`, sets `params_valid`, then → IDLE.
- `in_ready` = (state != COMMIT), decoded from registered state only; it has no combinational path from `in_valid`.
- A `SYNC_BYTE` value inside the payload is ordinary data. There is no resync mid-frame.
- `abort` is sampled every cycle and has priority over byte acceptance. It sends the FSM to IDLE from any state except COMMIT, which always completes. The shadow is left stale, and the live outputs and `params_valid` are unchanged.
- Reset values:
  - All live and shadow registers 0.
  - `cnt` 0, running sum 0, state IDLE.
  - `params_valid`, `load_done`, `load_err` 0.
  - `in_ready` 1.
- Reset asserted mid-frame discards the partial frame.

## Timing
- A byte is accepted at edge E. The shadow slot and counter reflect it after E.
- Last payload byte (or checksum byte) accepted at edge E:
  - State is COMMIT during cycle E..E+1.
  - `in_ready` is low during that cycle.
  - Live outputs, `params_valid` and `load_done` update at edge E+1. `load_done` is high for exactly one cycle.
- `load_err` is registered and goes high for one cycle after the edge that accepts a bad checksum byte.
- Minimum frame time: 29 cycles (30 with checksum) plus 1 commit cycle. Back-to-back frames are allowed: a new `SYNC_BYTE` is accepted on the cycle after COMMIT.
- `in_valid` may drop at any time; gaps stall the counter with no timeout.

## Configuration
- `DNN_PARAM_CHECKSUM_EN` defined: a trailing checksum byte is required, the CHECK state exists, and `load_err` is functional.
- `DNN_PARAM_CHECKSUM_EN` undefined: no CHECK state and no sum register, the frame is 29 bytes, and `load_err` is tied 0.

## Structure
- Package `dnn_param_pkg` holds:
  - Count constants `N_W1`, `N_W2`, `N_B1`, `N_B2`, and `PAYLOAD_BYTES` = 28
  - `SYNC_BYTE`
  - State enum `{IDLE, LOAD, CHECK, COMMIT}`
  - Slot-offset constants `W2_BASE` = 12, `B1_BASE` = 18, `B2_BASE` = 24
- No sub-module. The shadow register file plus its byte-addressed write decode lives inline.

## Test plan
- Reset with no traffic → all outputs 0, `params_valid` 0, `in_ready` 1.
- Send `A5` plus the standard parameter set:
  - Bytes include `weights_layer1[2]`=FE and `bias_layer1[1]`=FE FF.
  - Expect `weights_layer1[2]`==8'hFE, `bias_layer1[1]`==16'hFFFE, `bias_layer2[1]`==16'hFFD1.
  - `load_done` pulses once, 1 cycle after the last byte.
- Leading garbage `00 5A 13` before `A5` → dropped. The frame loads identically to the previous scenario.
- Assert `abort` after byte 10 of a frame whose payload is all `11`, then send a full frame → live values equal the second frame only, with no partial update visible.
- Random `in_valid` gaps of 0–5 cycles across a frame → same result as gapless. `in_ready` is low for exactly 1 cycle per frame.
- With `DNN_PARAM_CHECKSUM_EN`:
  - Checksum off by 1 → `load_err` pulse, outputs unchanged, `params_valid` unchanged.
  - Correct checksum → commit as in the second scenario.
